seq_comparator: RTL and testbench

SEQ_COMPARATOR -- requirements
Module: seq_comparator

---
 rtl/seq_comparator.sv | 134 +++++++++++++
 tb/tb_seq_comparator.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/seq_comparator.sv
// Serial magnitude comparator: walks K-bit slices from the MSB end and stops at
// the first differing slice, reporting lesser/greater/equal and slices examined.
module seq_comparator #(
  parameter int N = 32,
  parameter int K = 8,
  localparam int S = N / K,
  localparam int CW = $clog2(S) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  input  logic          is_signed,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          lesser,
  output logic          greater,
  output logic          equal,
  output logic [CW-1:0] cycles,
  output logic [1:0]    dbg_state
);

  // Handshake: operands transfer on a rising edge with in_valid && in_ready;
  // the result transfers on a rising edge with out_valid && out_ready. Only one
  // operation is in flight, so in_ready and out_valid are never both high.

  localparam int IW = (S > 1) ? $clog2(S) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPARE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d;
  logic          signed_q, signed_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cycles_q, cycles_d;
  logic          lesser_q, lesser_d;
  logic          greater_q, greater_d;
  logic          equal_q, equal_d;
  logic [K-1:0]  sa, sb;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    signed_d  = signed_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    cycles_d  = cycles_q;
    lesser_d  = lesser_q;
    greater_d = greater_q;
    equal_d   = equal_q;
    sa        = a_q[idx_q*K +: K];
    sb        = b_q[idx_q*K +: K];
    // Flipping the sign bits of the top slice turns a signed compare into an unsigned one.
    if (signed_q && (idx_q == IW'(S - 1))) begin
      sa[K-1] = ~sa[K-1];
      sb[K-1] = ~sb[K-1];
    end
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          signed_d = is_signed;
          idx_d    = IW'(S - 1);
          cnt_d    = '0;
          state_d  = COMPARE;
        end
      end
      COMPARE: begin
        cnt_d = cnt_q + CW'(1);
        if (sa != sb) begin
          greater_d = (sa > sb);
          lesser_d  = (sa < sb);
          equal_d   = 1'b0;
          cycles_d  = cnt_d;
          state_d   = DONE;
        end else if (idx_q == '0) begin
          greater_d = 1'b0;
          lesser_d  = 1'b0;
          equal_d   = 1'b1;
          cycles_d  = cnt_d;
          state_d   = DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      signed_q  <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= '0;
      cycles_q  <= '0;
      lesser_q  <= 1'b0;
      greater_q <= 1'b0;
      equal_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      signed_q  <= signed_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      cycles_q  <= cycles_d;
      lesser_q  <= lesser_d;
      greater_q <= greater_d;
      equal_q   <= equal_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign lesser    = lesser_q;
  assign greater   = greater_q;
  assign equal     = equal_q;
  assign cycles    = cycles_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_comparator.sv
// Bench for seq_comparator (N=32, K=8): directed and random compares checked
// against a reference model through an expected-result queue.
module tb_seq_comparator;

  localparam int N  = 32;
  localparam int K  = 8;
  localparam int S  = N / K;
  localparam int CW = $clog2(S) + 1;
  localparam int W  = CW + 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  a, b;
  logic          is_signed;
  logic          out_valid;
  logic          out_ready;
  logic          lesser, greater, equal;
  logic [CW-1:0] cycles;
  logic [1:0]    dbg_state;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  seq_comparator #(.N(N), .K(K)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .is_signed(is_signed),
    .out_valid(out_valid), .out_ready(out_ready),
    .lesser(lesser), .greater(greater), .equal(equal),
    .cycles(cycles), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {lesser, greater, equal, cycles}
  function automatic logic [W-1:0] model(input logic [N-1:0] x, input logic [N-1:0] y, input logic s);
    int k;
    logic lt, gt, eq;
    k = S;
    for (int i = S - 1; i >= 0; i--) begin
      if (x[i*K +: K] != y[i*K +: K]) begin
        k = S - i;
        break;
      end
    end
    eq = (x == y);
    lt = s ? ($signed(x) < $signed(y)) : (x < y);
    gt = !eq && !lt;
    return {lt, gt, eq, CW'(k)};
  endfunction

  task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y, input logic s, input int hold);
    logic [W-1:0] exp, obs;
    int edges;
    logic seen;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    a = x; b = y; is_signed = s; in_valid = 1'b1;
    exp_q.push_back(model(x, y, s));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; is_signed = 1'($urandom_range(0, 1));
    edges = 0;
    seen = 1'b0;
    for (int i = 0; i < S + 4 && !seen; i++) begin
      @(posedge clk);
      edges++;
      #1;
      if (out_valid) seen = 1'b1;
    end
    if (!seen) begin
      check("timeout_out_valid", 0, 1);
      void'(exp_q.pop_front());
      return;
    end
    exp = exp_q.pop_front();
    obs = {lesser, greater, equal, cycles};
    check("result", obs, exp);
    check("latency", edges, 32'(exp[CW-1:0]));
    check("onehot", $countones({lesser, greater, equal}), 1);
    check("in_ready_done", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      a = $urandom; b = $urandom;
      @(posedge clk);
      #1;
      check("hold_result", {lesser, greater, equal, cycles}, obs);
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    check("idle_keeps_result", {lesser, greater, equal, cycles}, obs);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [N-1:0] x, y;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; is_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_flags", {lesser, greater, equal}, 0);
    check("rst_cycles", cycles, 0);
    check("rst_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed vectors
    run_op(32'h12345678, 32'h12345678, 1'b0, 0);
    run_op(32'h80000000, 32'h7FFFFFFF, 1'b0, 0);
    run_op(32'h80000000, 32'h7FFFFFFF, 1'b1, 0);
    run_op(32'h0000FF00, 32'h0000FE00, 1'b0, 0);
    run_op(32'h00000010, 32'h00000011, 1'b0, 0);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 5);
    run_op(32'h00000080, 32'h00000000, 1'b1, 1);
    run_op(32'h00000000, 32'h00000000, 1'b1, 0);

    // random: y equals x except possibly in one slice, so every exit point is exercised
    for (int n = 0; n < 24; n++) begin
      int sl;
      x = $urandom;
      y = x;
      sl = $urandom_range(0, S);
      if (sl < S) y[sl*K +: K] = 8'($urandom);
      if ($urandom_range(0, 3) == 0) y = $urandom;
      run_op(x, y, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    // reset during the second COMPARE cycle aborts the operation
    @(negedge clk);
    a = 32'hCAFEF00D; b = 32'hCAFEF00D; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_flags", {lesser, greater, equal}, 0);
    check("abort_cycles", cycles, 0);
    check("abort_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
